// File: rtl/coeff_assemble.sv
// coeff_assemble
//   Collects one block of CAVLC levels (highest frequency first) and
//   run_before values. It places each nonzero level at its scan position
//   using TotalZeros and the runs. It then streams the whole block out in
//   scan order, index 0 first, under a valid/ready handshake.
//
// Ports
//   Clk         clock
//   Reset       synchronous, active-high reset
//   Start       begin a new block (honoured only when idle); samples
//               TotalCoeff and TotalZeros
//   TotalCoeff  nonzero coefficient count, 0..MAX_COEFF
//   TotalZeros  zeros before the last nonzero coefficient
//   LevelIn     signed level, valid with LevelWrReq (no backpressure)
//   RunIn       run_before for the current level, valid with RunValid
//   CoeffOut    registered coefficient value
//   CoeffIdx    scan index of CoeffOut
//   CoeffValid  CoeffOut/CoeffIdx valid; transfers when CoeffReady is high
//   CoeffReady  consumer ready
//   BlockDone   one-cycle pulse at the end of each block
//   Busy        high whenever the block engine is not idle
//   Error       sticky block error, cleared by the next accepted Start
module coeff_assemble #(
  parameter int MAX_COEFF = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic [4:0]         TotalCoeff,
  input  logic [3:0]         TotalZeros,
  input  logic signed [12:0] LevelIn,
  input  logic               LevelWrReq,
  input  logic [3:0]         RunIn,
  input  logic               RunValid,
  output logic signed [12:0] CoeffOut,
  output logic [3:0]         CoeffIdx,
  output logic               CoeffValid,
  input  logic               CoeffReady,
  output logic               BlockDone,
  output logic               Busy,
  output logic               Error
);

  localparam logic [5:0] MaxCoeff6 = 6'(MAX_COEFF);
  localparam logic [3:0] LastIdx   = 4'(MAX_COEFF - 1);

  typedef enum logic [2:0] {
    Idle,
    Collect,
    Place,
    Emit,
    Done
  } stateT;

  stateT state, stateNext;

  // Block parameters latched at Start.
  logic [4:0] tc;
  logic [3:0] tz;

  // Counters.
  logic [4:0]        lvlCnt, runCnt;
  logic [3:0]        placeIdx;
  logic signed [4:0] pos;
  logic [3:0]        zerosLeft;
  logic [3:0]        emitIdx;

  // Storage.
  logic signed [12:0] levelMem [MAX_COEFF];
  logic [3:0]         runMem   [MAX_COEFF];
  logic signed [12:0] coefMem  [MAX_COEFF];

  // Control strobes.
  logic [5:0] sumTcTz;
  logic       startTake, startBad;
  logic [4:0] runTarget;
  logic       lvlTake, lvlExtra, runTake, runExtra;
  logic [4:0] lvlCntNext, runCntNext;
  logic       collectDone;
  logic       placeLast;
  logic [3:0] runRaw, runUse;
  logic       runClamp;
  logic       handshake;

  assign sumTcTz   = {1'b0, TotalCoeff} + {2'b00, TotalZeros};
  assign startTake = (state == Idle) && Start;
  assign startBad  = (sumTcTz > MaxCoeff6) || ({1'b0, TotalCoeff} > MaxCoeff6);

  // tc is at least 1 while collecting or placing, so this never wraps there.
  assign runTarget = tc - 5'd1;

  assign lvlTake    = (state == Collect) && LevelWrReq && (lvlCnt < tc);
  assign lvlExtra   = (state == Collect) && LevelWrReq && (lvlCnt >= tc);
  assign runTake    = (state == Collect) && RunValid && (runCnt < runTarget);
  assign runExtra   = (state == Collect) && RunValid && (runCnt >= runTarget);
  assign lvlCntNext = lvlCnt + {4'd0, lvlTake};
  assign runCntNext = runCnt + {4'd0, runTake};

  // The exit test counts this cycle's writes, so PLACE starts right after the
  // edge that accepts the final level or run.
  assign collectDone = (lvlCntNext == tc) && (runCntNext == runTarget);

  assign placeLast = ({1'b0, placeIdx} == runTarget);
  assign runRaw    = runMem[placeIdx];
  assign runClamp  = runRaw > zerosLeft;
  assign runUse    = runClamp ? zerosLeft : runRaw;

  assign handshake = (state == Emit) && CoeffReady;

  assign CoeffValid = (state == Emit);
  assign BlockDone  = (state == Done);
  assign Busy       = (state != Idle);
  assign CoeffIdx   = emitIdx;

  // Next-state logic.
  always_comb begin
    // NOTE: default assigned first so every path drives stateNext; a missing
    // branch would otherwise infer a latch.
    stateNext = state;
    unique case (state)
      Idle: begin
        if (Start) begin
          if (startBad)                stateNext = Done;
          else if (TotalCoeff == 5'd0) stateNext = Emit;
          else                         stateNext = Collect;
        end
      end
      Collect: if (collectDone) stateNext = Place;
      Place:   if (placeLast) stateNext = Emit;
      Emit:    if (handshake && (emitIdx == LastIdx)) stateNext = Done;
      Done:    stateNext = Idle;
      default: stateNext = Idle;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge Clk) begin
    // NOTE: non-blocking assignments throughout clocked logic, so every
    // register samples pre-edge values regardless of statement order.
    if (Reset) begin
      state     <= Idle;
      tc        <= '0;
      tz        <= '0;
      lvlCnt    <= '0;
      runCnt    <= '0;
      placeIdx  <= '0;
      pos       <= '0;
      zerosLeft <= '0;
      emitIdx   <= '0;
      CoeffOut  <= '0;
      Error     <= 1'b0;
    end else begin
      state <= stateNext;
      unique case (state)
        Idle: begin
          if (Start) begin
            tc       <= TotalCoeff;
            tz       <= TotalZeros;
            lvlCnt   <= '0;
            runCnt   <= '0;
            emitIdx  <= '0;
            CoeffOut <= '0;
            Error    <= startBad;
          end
        end
        Collect: begin
          lvlCnt <= lvlCntNext;
          runCnt <= runCntNext;
          if (lvlExtra || runExtra) Error <= 1'b1;
          if (collectDone) begin
            pos       <= $signed(tc + {1'b0, tz} - 5'd1);
            zerosLeft <= tz;
            placeIdx  <= '0;
          end
        end
        Place: begin
          if (placeLast) begin
            emitIdx <= '0;
            // The final write may target index 0 on this very edge, so
            // forward the level rather than read the stale array entry.
            CoeffOut <= (pos == 5'sd0) ? levelMem[placeIdx] : coefMem[0];
          end else begin
            placeIdx  <= placeIdx + 4'd1;
            pos       <= pos - 5'sd1 - $signed({1'b0, runUse});
            zerosLeft <= zerosLeft - runUse;
            if (runClamp) Error <= 1'b1;
          end
        end
        Emit: begin
          // CoeffOut only advances on a transfer, so it holds while stalled.
          if (handshake && (emitIdx != LastIdx)) begin
            emitIdx  <= emitIdx + 4'd1;
            CoeffOut <= coefMem[emitIdx + 4'd1];
          end
        end
        default: ;
      endcase
    end
  end

  // Block storage. The coefficient array is cleared functionally at Start.
  always_ff @(posedge Clk) begin
    // NOTE: storage arrays carry no reset; nothing reads them before a new
    // block overwrites or clears them.
    if (lvlTake) levelMem[lvlCnt[3:0]] <= LevelIn;
    if (runTake) runMem[runCnt[3:0]]   <= RunIn;
    if (startTake) begin
      for (int i = 0; i < MAX_COEFF; i++) coefMem[i] <= '0;
    end else if (state == Place) begin
      coefMem[pos[3:0]] <= levelMem[placeIdx];
    end
  end

endmodule

// File: tb/tb_coeff_assemble.sv
// tb_coeff_assemble
//   Directed bench for coeff_assemble. A table of block records holds the
//   stimulus and the hand-placed scan-order results. Each record is driven
//   and then drained and compared. Hand-written sequences cover Start-time
//   errors, reset during emission and stray inputs while idle.
module tb_coeff_assemble;

  localparam int N = 16;

  logic               Clk = 1'b0;
  logic               Reset;
  logic               Start;
  logic [4:0]         TotalCoeff;
  logic [3:0]         TotalZeros;
  logic signed [12:0] LevelIn;
  logic               LevelWrReq;
  logic [3:0]         RunIn;
  logic               RunValid;
  logic signed [12:0] CoeffOut;
  logic [3:0]         CoeffIdx;
  logic               CoeffValid;
  logic               CoeffReady;
  logic               BlockDone;
  logic               Busy;
  logic               Error;

  coeff_assemble #(.MAX_COEFF(N)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .TotalCoeff (TotalCoeff),
    .TotalZeros (TotalZeros),
    .LevelIn    (LevelIn),
    .LevelWrReq (LevelWrReq),
    .RunIn      (RunIn),
    .RunValid   (RunValid),
    .CoeffOut   (CoeffOut),
    .CoeffIdx   (CoeffIdx),
    .CoeffValid (CoeffValid),
    .CoeffReady (CoeffReady),
    .BlockDone  (BlockDone),
    .Busy       (Busy),
    .Error      (Error)
  );

  always #5 Clk = ~Clk;

  int passCnt  = 0;
  int checkCnt = 0;

  typedef struct {
    string name;
    int    tc;
    int    tz;
    int    nLv;       // levels driven (more than tc exercises the overflow)
    int    lv [N+1];
    int    rn [N];
    int    expv [N];  // expected coefficient per scan index
    bit    expErr;
    bit    inter;     // level and run together, with gaps
    int    gap;
    bit    bp;        // CoeffReady pattern 1,0,0,1,...
  } vecT;

  vecT vecs [$];

  task automatic check(input string name, input int act, input int req);
    checkCnt++;
    if (act == req) passCnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after it.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  function automatic vecT blank(input string name, input int tc, input int tz);
    vecT v;
    v.name = name; v.tc = tc; v.tz = tz; v.nLv = tc;
    v.expErr = 1'b0; v.inter = 1'b0; v.gap = 0; v.bp = 1'b0;
    for (int i = 0; i <= N; i++) v.lv[i] = 0;
    for (int i = 0; i < N; i++) begin
      v.rn[i] = 0;
      v.expv[i] = 0;
    end
    return v;
  endfunction

  task automatic runBlock(input vecT v, input int abortAfter);
    int lat, got, cyc, prevVal, prevIdx;
    bit stalled, rdy;
    TotalCoeff = 5'(v.tc);
    TotalZeros = 4'(v.tz);
    Start = 1'b1;
    step();
    Start = 1'b0;
    check({v.name, " busy after start"}, int'(Busy), 1);
    check({v.name, " error cleared"}, int'(Error), 0);

    if (v.inter) begin
      for (int k = 0; k < v.tc; k++) begin
        LevelIn = 13'(v.lv[k]);
        LevelWrReq = 1'b1;
        if (k < v.tc - 1) begin
          RunIn = 4'(v.rn[k]);
          RunValid = 1'b1;
        end
        step();
        LevelWrReq = 1'b0;
        RunValid = 1'b0;
        if (k < v.tc - 1) repeat (v.gap) step();
      end
    end else begin
      for (int k = 0; k < v.nLv; k++) begin
        LevelIn = 13'(v.lv[k]);
        LevelWrReq = 1'b1;
        step();
        LevelWrReq = 1'b0;
      end
      for (int k = 0; k < v.tc - 1; k++) begin
        RunIn = 4'(v.rn[k]);
        RunValid = 1'b1;
        step();
        RunValid = 1'b0;
      end
    end

    // PLACE takes exactly tc cycles after the final input edge.
    lat = 0;
    while (!CoeffValid && lat < 64) begin
      step();
      lat++;
    end
    check({v.name, " latency"}, lat, v.tc);

    got = 0; cyc = 0; stalled = 1'b0; prevVal = 0; prevIdx = 0;
    while (got < N && cyc < 200) begin
      check($sformatf("%s valid cyc%0d", v.name, cyc), int'(CoeffValid), 1);
      if (stalled) begin
        check($sformatf("%s stable val cyc%0d", v.name, cyc), int'(CoeffOut), prevVal);
        check($sformatf("%s stable idx cyc%0d", v.name, cyc), int'(CoeffIdx), prevIdx);
      end
      rdy = v.bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      CoeffReady = rdy;
      if (CoeffValid && rdy) begin
        check($sformatf("%s idx%0d", v.name, got), int'(CoeffIdx), got);
        check($sformatf("%s coeff%0d", v.name, got), int'(CoeffOut), v.expv[got]);
        got++;
      end
      stalled = CoeffValid && !rdy;
      prevVal = int'(CoeffOut);
      prevIdx = int'(CoeffIdx);
      step();
      cyc++;
      if (abortAfter > 0 && got == abortAfter) begin
        CoeffReady = 1'b0;
        return;
      end
    end
    check({v.name, " transfers"}, got, N);
    CoeffReady = 1'b0;

    check({v.name, " done pulse"}, int'(BlockDone), 1);
    check({v.name, " valid low at done"}, int'(CoeffValid), 0);
    check({v.name, " error"}, int'(Error), int'(v.expErr));
    step();
    check({v.name, " done cleared"}, int'(BlockDone), 0);
    check({v.name, " idle"}, int'(Busy), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecT v, std;

    // Standard block: Pos starts at 7; walking the runs places 1@7, 1@5,
    // -1@4, -1@1 and 3@0.
    std = blank("standard", 5, 3);
    std.lv[0] = 1; std.lv[1] = 1; std.lv[2] = -1; std.lv[3] = -1; std.lv[4] = 3;
    std.rn[0] = 1; std.rn[1] = 0; std.rn[2] = 2; std.rn[3] = 0;
    std.expv[0] = 3; std.expv[1] = -1; std.expv[4] = -1; std.expv[5] = 1; std.expv[7] = 1;
    vecs.push_back(std);

    v = std; v.name = "backpressure"; v.bp = 1'b1;
    vecs.push_back(v);

    v = std; v.name = "interleaved"; v.inter = 1'b1; v.gap = 3;
    vecs.push_back(v);

    // Empty block, run after nonzero blocks so stale values would show.
    v = blank("empty", 0, 0);
    vecs.push_back(v);

    // Same levels and runs with TZ=4: the last level keeps one zero below it.
    v = std; v.name = "tz4"; v.tz = 4;
    for (int i = 0; i < N; i++) v.expv[i] = 0;
    v.expv[1] = 3; v.expv[2] = -1; v.expv[5] = -1; v.expv[6] = 1; v.expv[8] = 1;
    vecs.push_back(v);

    // Run 3 exceeds the single remaining zero and is clamped to 1.
    v = blank("run clamp", 2, 1);
    v.lv[0] = 5; v.lv[1] = -7; v.rn[0] = 3;
    v.expv[0] = -7; v.expv[2] = 5; v.expErr = 1'b1;
    vecs.push_back(v);

    // Full block, no zeros: level k lands at index 15-k, full 13-bit range.
    v = blank("full16", 16, 0);
    for (int k = 0; k < N; k++) v.lv[k] = (k % 2 == 0) ? (k * 37 + 1) : -(k * 41);
    v.lv[0] = 4095; v.lv[15] = -4096;
    for (int k = 0; k < N; k++) v.expv[N-1-k] = v.lv[k];
    vecs.push_back(v);

    // One coefficient with TC+TZ at the limit: it sits at index 15.
    v = blank("tc1 tz15", 1, 15);
    v.lv[0] = 9; v.expv[15] = 9;
    vecs.push_back(v);

    // A third level beyond TC=2 is discarded and flags an error.
    v = blank("extra level", 2, 0);
    v.nLv = 3; v.lv[0] = 11; v.lv[1] = -22; v.lv[2] = 33;
    v.expv[0] = -22; v.expv[1] = 11; v.expErr = 1'b1;
    vecs.push_back(v);

    Reset = 1'b1; Start = 1'b0; TotalCoeff = '0; TotalZeros = '0;
    LevelIn = '0; LevelWrReq = 1'b0; RunIn = '0; RunValid = 1'b0; CoeffReady = 1'b0;
    step();
    step();
    check("reset CoeffOut", int'(CoeffOut), 0);
    check("reset CoeffIdx", int'(CoeffIdx), 0);
    check("reset CoeffValid", int'(CoeffValid), 0);
    check("reset BlockDone", int'(BlockDone), 0);
    check("reset Busy", int'(Busy), 0);
    check("reset Error", int'(Error), 0);
    Reset = 1'b0;
    step();

    // TC+TZ over the limit: immediate error and BlockDone, no coefficients.
    TotalCoeff = 5'd10; TotalZeros = 4'd8; Start = 1'b1;
    step();
    Start = 1'b0;
    check("tc10tz8 BlockDone", int'(BlockDone), 1);
    check("tc10tz8 Error", int'(Error), 1);
    check("tc10tz8 CoeffValid", int'(CoeffValid), 0);
    step();
    check("tc10tz8 BlockDone end", int'(BlockDone), 0);
    check("tc10tz8 Busy end", int'(Busy), 0);
    check("tc10tz8 Error sticky", int'(Error), 1);
    check("tc10tz8 CoeffValid end", int'(CoeffValid), 0);

    // TC alone above the limit.
    TotalCoeff = 5'd17; TotalZeros = 4'd0; Start = 1'b1;
    step();
    Start = 1'b0;
    check("tc17 BlockDone", int'(BlockDone), 1);
    check("tc17 Error", int'(Error), 1);
    step();

    foreach (vecs[i]) runBlock(vecs[i], 0);

    // Reset after five transfers, then a clean standard block.
    runBlock(std, 5);
    Reset = 1'b1;
    step();
    check("midreset CoeffOut", int'(CoeffOut), 0);
    check("midreset CoeffIdx", int'(CoeffIdx), 0);
    check("midreset CoeffValid", int'(CoeffValid), 0);
    check("midreset BlockDone", int'(BlockDone), 0);
    check("midreset Busy", int'(Busy), 0);
    Reset = 1'b0;
    step();
    std.name = "after reset";
    runBlock(std, 0);

    // Level/run strobes while idle are ignored without an error.
    LevelWrReq = 1'b1; RunValid = 1'b1;
    step();
    LevelWrReq = 1'b0; RunValid = 1'b0;
    check("idle strobes Error", int'(Error), 0);
    check("idle strobes Busy", int'(Busy), 0);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
